// File: rtl/fetch_pkg.sv
// Shared encodings for the MUSA fetch stage: next-PC selects, FSM states, PC step.
package fetch_pkg;
  localparam logic [2:0] PC_SEQ  = 3'd0;
  localparam logic [2:0] PC_BR   = 3'd1;
  localparam logic [2:0] PC_JMP  = 3'd2;
  localparam logic [2:0] PC_CALL = 3'd3;
  localparam logic [2:0] PC_RET  = 3'd4;

  typedef enum logic {FETCH, HOLD} fetch_state_e;

  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/fetch_stage_return_stack.sv
// Hardware return-address stack with sticky overflow/underflow flags.
module return_stack #(
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] top,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        underflow
);
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;

  logic [31:0]    mem [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_m1;
  logic [AW-1:0]  top_idx;
  logic [AW-1:0]  wr_idx;

  assign sp_m1   = sp - SPW'(1);
  assign top_idx = sp_m1[AW-1:0];
  assign wr_idx  = sp[AW-1:0];
  assign empty   = (sp == '0);
  assign full    = (sp == SPW'(STACK_DEPTH));
  assign top     = mem[top_idx];

  // Push+pop replaces the top entry; on an empty stack it lands in slot 0.
  always_ff @(posedge clk) begin
    if (en && push) begin
      if (pop)        mem[empty ? '0 : top_idx] <= wdata;
      else if (!full) mem[wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (en) begin
      if (push && pop) begin
        if (empty) begin
          underflow <= 1'b1;
          sp        <= SPW'(1);
        end
      end else if (push) begin
        if (full) overflow <= 1'b1;
        else      sp <= sp + SPW'(1);
      end else if (pop) begin
        if (empty) underflow <= 1'b1;
        else       sp <= sp_m1;
      end
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// MUSA instruction fetch: PC, instruction register, imem handshake and next-PC select.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic [2:0]  pc_src,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  input  logic        push,
  input  logic        pop,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        stack_overflow,
  output logic        stack_underflow
);
  fetch_state_e state, state_nxt;
  logic         commit;
  logic [31:0]  next_pc;
  logic [31:0]  stk_top;
  logic         stk_empty;
  logic         stk_full;

  assign pc_plus4  = pc + PC_INC;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    commit    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = !rst;
        if (imem_ready) state_nxt = HOLD;
      end
      HOLD: begin
        if (pc_write) begin
          commit    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Return target is the pre-pop top; an empty stack falls back to RESET_PC.
  always_comb begin
    case (pc_src)
      PC_SEQ:          next_pc = pc_plus4;
      PC_BR:           next_pc = branch_target;
      PC_JMP, PC_CALL: next_pc = {pc_plus4[31:28], jump_target[27:0]};
      PC_RET:          next_pc = stk_empty ? RESET_PC : stk_top;
      default:         next_pc = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (state == FETCH && imem_ready) begin
        instruction <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (commit) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
    end
  end

  return_stack #(.STACK_DEPTH(STACK_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .en        (commit),
    .push      (push),
    .pop       (pop),
    .wdata     (pc_plus4),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full),
    .overflow  (stack_overflow),
    .underflow (stack_underflow)
  );

  logic unused_full;
  assign unused_full = stk_full;
endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: queue-based reference model checked every cycle, directed plus random stimulus.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic [2:0]  pc_src = 3'd0;
  logic [31:0] jump_target = '0, branch_target = '0;
  logic        push = 1'b0, pop = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, instr_valid, stack_overflow, stack_underflow;
  logic [31:0] imem_addr, instruction, pc, pc_plus4;

  fetch_stage #(.RESET_PC(RST_PC), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_src(pc_src),
    .jump_target(jump_target), .branch_target(branch_target),
    .push(push), .pop(pop), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
  endtask

  // Reference model: "waiting for memory" flag, plain values and a queue as the stack.
  logic [31:0] m_pc = RST_PC, m_instr = '0;
  bit          m_fetching = 1, m_valid = 0, m_ovf = 0, m_unf = 0;
  logic [31:0] m_stk[$];
  bit          chk_en = 0;

  always @(posedge clk) begin
    logic [31:0] nxt, pp;
    pp = m_pc + 32'd4;
    if (rst) begin
      m_pc = RST_PC; m_fetching = 1; m_instr = '0; m_valid = 0;
      m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_fetching) begin
      if (imem_ready) begin m_instr = imem_rdata; m_valid = 1; m_fetching = 0; end
    end else if (pc_write) begin
      case (pc_src)
        3'd0:       nxt = pp;
        3'd1:       nxt = branch_target;
        3'd2, 3'd3: nxt = {pp[31:28], jump_target[27:0]};
        3'd4:       nxt = (m_stk.size() > 0) ? m_stk[$] : RST_PC;
        default:    nxt = m_pc;
      endcase
      if (push && pop) begin
        if (m_stk.size() == 0) begin m_unf = 1; m_stk.push_back(pp); end
        else m_stk[m_stk.size()-1] = pp;
      end else if (push) begin
        if (m_stk.size() == DEPTH) m_ovf = 1; else m_stk.push_back(pp);
      end else if (pop) begin
        if (m_stk.size() == 0) m_unf = 1; else void'(m_stk.pop_back());
      end
      m_pc = nxt; m_valid = 0; m_fetching = 1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetching && !rst});
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("instruction", instruction, m_instr);
      chk("overflow", {31'd0, stack_overflow}, {31'd0, m_ovf});
      chk("underflow", {31'd0, stack_underflow}, {31'd0, m_unf});
    end
  end

  // Entered in FETCH at a negedge; leaves in HOLD at a negedge.
  task automatic fetch_one(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0; imem_rdata = $urandom;
      @(negedge clk);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("fetched_valid", {31'd0, instr_valid}, 32'd1);
    chk("fetched_word", instruction, word);
  endtask

  task automatic commit(input logic [2:0] src, input logic [31:0] jt, input logic [31:0] bt,
                        input logic pu, input logic po);
    pc_write = 1'b1; pc_src = src; jump_target = jt; branch_target = bt; push = pu; pop = po;
    @(negedge clk);
    pc_write = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("req_in_reset", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    #1 chk("req_after_reset", {31'd0, imem_req}, 32'd1);
    chk("pc_reset", pc, 32'h0);
    @(negedge clk);
    // sequential fetch
    fetch_one(32'hAAAA_0001, 0); commit(3'd0, 0, 0, 0, 0);
    chk("seq_addr1", imem_addr, 32'h4);
    fetch_one(32'hAAAA_0002, 0); commit(3'd0, 0, 0, 0, 0);
    chk("seq_addr2", imem_addr, 32'h8);
    fetch_one(32'hBBBB_0003, 3);
    // jump and branch
    commit(3'd1, 0, 32'h1000_0010, 0, 0);
    chk("br_pc", pc, 32'h1000_0010);
    fetch_one($urandom, 0); commit(3'd2, 32'h0000_0400, 0, 0, 0);
    chk("jmp_pc", pc, 32'h1000_0400);
    fetch_one($urandom, 0); commit(3'd1, 0, 32'h80, 0, 0);
    chk("br_pc2", pc, 32'h80);
    // call / return
    fetch_one($urandom, 0); commit(3'd1, 0, 32'h20, 0, 0);
    fetch_one($urandom, 1); commit(3'd3, 32'h100, 0, 1, 0);
    chk("call_pc", pc, 32'h100);
    fetch_one($urandom, 0); commit(3'd4, 0, 0, 0, 1);
    chk("ret_pc", pc, 32'h24);
    chk("ret_no_unf", {31'd0, stack_underflow}, 32'd0);
    // overflow: 9 pushes, top keeps the 8th return address
    for (int i = 0; i < 9; i++) begin fetch_one($urandom, 0); commit(3'd0, 0, 0, 1, 0); end
    chk("ovf_set", {31'd0, stack_overflow}, 32'd1);
    fetch_one($urandom, 0); commit(3'd4, 0, 0, 0, 0);
    chk("ovf_top", pc, 32'h44);
    for (int i = 0; i < 8; i++) begin fetch_one($urandom, 0); commit(3'd0, 0, 0, 0, 1); end
    chk("no_unf_yet", {31'd0, stack_underflow}, 32'd0);
    fetch_one($urandom, 0); commit(3'd4, 0, 0, 0, 1);
    chk("unf_set", {31'd0, stack_underflow}, 32'd1);
    chk("unf_pc", pc, RST_PC);
    // reset mid-fetch
    imem_ready = 1'b1; rst = 1'b1;
    #1 chk("req_rst_mid", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0;
    chk("rst_pc", pc, RST_PC);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
    // random phase
    for (int n = 0; n < 4000; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      imem_ready    = ($urandom_range(0, 9) < 6);
      imem_rdata    = $urandom;
      pc_write      = ($urandom_range(0, 1) == 1);
      pc_src        = 3'($urandom_range(0, 7));
      jump_target   = $urandom;
      branch_target = $urandom;
      push          = ($urandom_range(0, 9) < 4);
      pop           = ($urandom_range(0, 9) < 3);
      @(negedge clk);
    end
    rst = 1'b0; pc_write = 1'b0; push = 1'b0; pop = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
